// File: rtl/vc_host_loader_pkg.sv
// Shared constants for the videocard host loader: FSM encodings, card RAM and
// control-port address map, and core count.
package vc_host_loader_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned RB_ST_W   = 2;
    localparam int unsigned CTL_AW    = 3;
    localparam int unsigned NUM_CORES = 4;

    // Main sequencer states
    localparam logic [STATE_W-1:0] S_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] S_LOAD_DATA = 4'd1;
    localparam logic [STATE_W-1:0] S_LOAD_PROG = 4'd2;
    localparam logic [STATE_W-1:0] S_CORE_EN   = 4'd3;
    localparam logic [STATE_W-1:0] S_START     = 4'd4;
    localparam logic [STATE_W-1:0] S_POLL      = 4'd5;
    localparam logic [STATE_W-1:0] S_READBACK  = 4'd6;
    localparam logic [STATE_W-1:0] S_FINISH    = 4'd7;
    localparam logic [STATE_W-1:0] S_ERROR     = 4'd8;

    // Readback unit states
    localparam logic [RB_ST_W-1:0] RB_IDLE  = 2'd0;
    localparam logic [RB_ST_W-1:0] RB_ISSUE = 2'd1;
    localparam logic [RB_ST_W-1:0] RB_WAIT  = 2'd2;
    localparam logic [RB_ST_W-1:0] RB_HOLD  = 2'd3;

    // Card memory map: bit 16 selects program memory
    localparam logic [16:0] PROG_BASE = 17'h10000;

    // Card control-port register map
    localparam logic [CTL_AW-1:0] CTL_START  = 3'd0;
    localparam logic [CTL_AW-1:0] CTL_STATUS = 3'd1;
    localparam logic [CTL_AW-1:0] CTL_CORE0  = 3'd2;

endpackage

// File: rtl/vc_readback_unit.sv
// Readback engine: issues one card RAM read at a time from base_i upward,
// waits RD_LAT cycles, and presents each word on a valid/ready stream.
// Ports: start_i pulse begins a run of count_i words at base_i; read_o /
// address_o drive the card port; rdata_i returns data; m_data_o / m_valid_o /
// m_ready_i form the output stream; done_o pulses on the last handshake.
module vc_readback_unit
    import vc_host_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] count_i,
    input  logic [WIDTH-1:0]  rdata_i,
    input  logic              m_ready_i,
    output logic              read_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [WIDTH-1:0]  m_data_o,
    output logic              m_valid_o,
    output logic              done_o
);

    localparam int unsigned LW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    logic [RB_ST_W-1:0] st_q, st_d;
    logic [ADDR_W-1:0]  j_q, j_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;

    // State and capture registers
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= RB_IDLE;
            j_q     <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            j_q     <= j_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // j_q counts reads issued; the next read goes out in the same cycle the
    // held word is accepted, giving RD_LAT+1 cycles per word at full rate.
    always_comb begin
        st_d      = st_q;
        j_d       = j_q;
        lat_d     = lat_q;
        data_d    = data_q;
        valid_d   = valid_q;
        read_o    = 1'b0;
        address_o = '0;
        done_o    = 1'b0;
        case (st_q)
            RB_IDLE: begin
                if (start_i) begin
                    j_d  = '0;
                    st_d = RB_ISSUE;
                end
            end
            RB_ISSUE: begin
                read_o    = 1'b1;
                address_o = base_i + j_q;
                j_d       = j_q + ADDR_W'(1);
                lat_d     = LW'(1);
                st_d      = RB_WAIT;
            end
            RB_WAIT: begin
                if (lat_q == LW'(RD_LAT)) begin
                    data_d  = rdata_i;
                    valid_d = 1'b1;
                    st_d    = RB_HOLD;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            RB_HOLD: begin
                if (m_ready_i) begin
                    valid_d = 1'b0;
                    if (j_q == count_i) begin
                        done_o = 1'b1;
                        st_d   = RB_IDLE;
                    end else begin
                        read_o    = 1'b1;
                        address_o = base_i + j_q;
                        j_d       = j_q + ADDR_W'(1);
                        lat_d     = LW'(1);
                        st_d      = RB_WAIT;
                    end
                end
            end
            default: st_d = RB_IDLE;
        endcase
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;

endmodule

// File: rtl/vc_host_loader.sv
// Host-side sequencer for videocard_top: streams data and program images into
// card RAM, enables cores, starts the card, polls for completion and streams a
// result region back out.
// Ports: cmd_start + command fields (bases, counts, core_mask); s_* image
// stream in; m_* readback stream out; busy/done/err status; vc_* card memory
// port; ctl_* card control port.
module vc_host_loader
    import vc_host_loader_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset_sink_reset,
    input  logic                 cmd_start,
    input  logic [ADDR_W-1:0]    data_base,
    input  logic [ADDR_W-1:0]    data_count,
    input  logic [ADDR_W-1:0]    prog_count,
    input  logic [ADDR_W-1:0]    rb_base,
    input  logic [ADDR_W-1:0]    rb_count,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    vc_address,
    output logic [WIDTH-1:0]     vc_wdata,
    output logic                 vc_write,
    output logic                 vc_read,
    input  logic [WIDTH-1:0]     vc_rdata,
    output logic [3:0]           vc_byteenable,
    output logic [CTL_AW-1:0]    ctl_address,
    output logic [WIDTH-1:0]     ctl_wdata,
    output logic                 ctl_write,
    output logic                 ctl_read,
    input  logic [WIDTH-1:0]     ctl_rdata
);

    localparam int unsigned PCW = $clog2(TIMEOUT + 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]    data_base_q, data_base_d, data_cnt_q, data_cnt_d;
    logic [ADDR_W-1:0]    prog_cnt_q, prog_cnt_d;
    logic [ADDR_W-1:0]    rb_base_q, rb_base_d, rb_cnt_q, rb_cnt_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [PCW-1:0]       poll_q, poll_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 rb_start_c, rb_done_c, rb_read_c;
    logic [ADDR_W-1:0]    rb_address_c;
    logic                 unused_ctl_c;

    assign unused_ctl_c = ^ctl_rdata[WIDTH-1:1];

    // Sequencer registers
    always_ff @(posedge clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            data_base_q <= '0;
            data_cnt_q  <= '0;
            prog_cnt_q  <= '0;
            rb_base_q   <= '0;
            rb_cnt_q    <= '0;
            mask_q      <= '0;
            poll_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_base_q <= data_base_d;
            data_cnt_q  <= data_cnt_d;
            prog_cnt_q  <= prog_cnt_d;
            rb_base_q   <= rb_base_d;
            rb_cnt_q    <= rb_cnt_d;
            mask_q      <= mask_d;
            poll_q      <= poll_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_base_d = data_base_q;
        data_cnt_d  = data_cnt_q;
        prog_cnt_d  = prog_cnt_q;
        rb_base_d   = rb_base_q;
        rb_cnt_d    = rb_cnt_q;
        mask_d      = mask_q;
        poll_d      = poll_q;
        done_d      = done_q;
        err_d       = err_q;
        rb_start_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    data_base_d = data_base;
                    data_cnt_d  = data_count;
                    prog_cnt_d  = prog_count;
                    rb_base_d   = rb_base;
                    rb_cnt_d    = rb_count;
                    mask_d      = core_mask;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    idx_d       = '0;
                    if (data_count != '0)      state_d = S_LOAD_DATA;
                    else if (prog_count != '0) state_d = S_LOAD_PROG;
                    else                       state_d = S_CORE_EN;
                end
            end
            S_LOAD_DATA: begin
                if (s_valid) begin
                    if (idx_q == data_cnt_q - ADDR_W'(1)) begin
                        idx_d   = '0;
                        state_d = (prog_cnt_q != '0) ? S_LOAD_PROG : S_CORE_EN;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_LOAD_PROG: begin
                if (s_valid) begin
                    if (idx_q == prog_cnt_q - ADDR_W'(1)) begin
                        idx_d   = '0;
                        state_d = S_CORE_EN;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_CORE_EN: begin
                if (idx_q[1:0] == 2'(NUM_CORES - 1)) begin
                    idx_d   = '0;
                    state_d = S_START;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_START: begin
                poll_d  = '0;
                state_d = S_POLL;
            end
            S_POLL: begin
                // Status read issued on entry returns one cycle later.
                if ((poll_q != '0) && ctl_rdata[0]) begin
                    if (rb_cnt_q != '0) begin
                        rb_start_c = 1'b1;
                        state_d    = S_READBACK;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (poll_q == PCW'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    poll_d = poll_q + PCW'(1);
                end
            end
            S_READBACK: begin
                if (rb_done_c) state_d = S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load writes follow the stream handshake in the same cycle.
    assign s_ready  = (state_q == S_LOAD_DATA) || (state_q == S_LOAD_PROG);
    assign vc_write = s_ready && s_valid;
    assign vc_wdata = vc_write ? s_data : '0;
    assign vc_read  = rb_read_c;

    // Card memory address and control-port decode
    always_comb begin
        vc_address  = rb_address_c;
        ctl_address = '0;
        ctl_wdata   = '0;
        ctl_write   = 1'b0;
        ctl_read    = 1'b0;
        case (state_q)
            S_LOAD_DATA: vc_address = data_base_q + idx_q;
            S_LOAD_PROG: vc_address = ADDR_W'(PROG_BASE) | ADDR_W'(idx_q[15:0]);
            S_CORE_EN: begin
                ctl_write   = 1'b1;
                ctl_address = CTL_CORE0 + CTL_AW'(idx_q[1:0]);
                ctl_wdata   = WIDTH'(mask_q[idx_q[1:0]]);
            end
            S_START: begin
                ctl_write   = 1'b1;
                ctl_address = CTL_START;
                ctl_wdata   = WIDTH'(1);
            end
            S_POLL: begin
                ctl_read    = 1'b1;
                ctl_address = CTL_STATUS;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign vc_byteenable = 4'b1111;

    vc_readback_unit #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_readback (
        .clk       (clk),
        .rst_i     (reset_sink_reset),
        .start_i   (rb_start_c),
        .base_i    (rb_base_q),
        .count_i   (rb_cnt_q),
        .rdata_i   (vc_rdata),
        .m_ready_i (m_ready),
        .read_o    (rb_read_c),
        .address_o (rb_address_c),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .done_o    (rb_done_c)
    );

endmodule

// File: tb/tb_vc_host_loader.sv
// Scoreboard bench for vc_host_loader: directed runs push expected card
// writes, control writes and readback words; a negedge monitor compares them.
module tb_vc_host_loader;

    logic        clk;
    logic        rst;
    logic        cmd_start, cmd_start_to;
    logic [16:0] data_base, data_count, prog_count, rb_base, rb_count;
    logic [3:0]  core_mask;
    logic [31:0] s_data;
    logic        s_valid, m_ready;

    logic        s_ready, m_valid, busy, done, err, vc_write, vc_read, ctl_write, ctl_read;
    logic [31:0] m_data, vc_wdata, ctl_wdata;
    logic [16:0] vc_address;
    logic [3:0]  vc_byteenable;
    logic [2:0]  ctl_address;
    logic [31:0] vc_rdata, ctl_rdata;

    logic        to_s_ready, to_m_valid, to_busy, to_done, to_err, to_vc_write, to_vc_read;
    logic        to_ctl_write, to_ctl_read;
    logic [31:0] to_m_data, to_vc_wdata, to_ctl_wdata;
    logic [16:0] to_vc_address;
    logic [3:0]  to_vc_be;
    logic [2:0]  to_ctl_address;
    logic [31:0] zero_w;

    int checks = 0;
    int errors = 0;

    logic [48:0] exp_vc[$];
    logic [48:0] exp_ctl[$];
    logic [48:0] exp_ctl_to[$];
    logic [31:0] exp_m[$];

    logic        status_bit;
    logic        rb_alt;
    logic [31:0] mem [0:63] = '{7: 32'd1, 8: 32'd2, 9: 32'd3, default: 32'd0};

    assign zero_w = '0;

    vc_host_loader dut (
        .clk(clk), .reset_sink_reset(rst), .cmd_start(cmd_start),
        .data_base(data_base), .data_count(data_count), .prog_count(prog_count),
        .rb_base(rb_base), .rb_count(rb_count), .core_mask(core_mask),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err),
        .vc_address(vc_address), .vc_wdata(vc_wdata), .vc_write(vc_write),
        .vc_read(vc_read), .vc_rdata(vc_rdata), .vc_byteenable(vc_byteenable),
        .ctl_address(ctl_address), .ctl_wdata(ctl_wdata), .ctl_write(ctl_write),
        .ctl_read(ctl_read), .ctl_rdata(ctl_rdata)
    );

    vc_host_loader #(.TIMEOUT(100)) dut_to (
        .clk(clk), .reset_sink_reset(rst), .cmd_start(cmd_start_to),
        .data_base(data_base), .data_count(data_count), .prog_count(prog_count),
        .rb_base(rb_base), .rb_count(rb_count), .core_mask(core_mask),
        .s_data(s_data), .s_valid(s_valid), .s_ready(to_s_ready),
        .m_data(to_m_data), .m_valid(to_m_valid), .m_ready(m_ready),
        .busy(to_busy), .done(to_done), .err(to_err),
        .vc_address(to_vc_address), .vc_wdata(to_vc_wdata), .vc_write(to_vc_write),
        .vc_read(to_vc_read), .vc_rdata(zero_w), .vc_byteenable(to_vc_be),
        .ctl_address(to_ctl_address), .ctl_wdata(to_ctl_wdata), .ctl_write(to_ctl_write),
        .ctl_read(to_ctl_read), .ctl_rdata(zero_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Card RAM (one-cycle read latency) and status register models
    always @(posedge clk) begin
        if (vc_write) mem[{vc_address[16], vc_address[4:0]}] <= vc_wdata;
        if (vc_read)  vc_rdata <= mem[{vc_address[16], vc_address[4:0]}];
        ctl_rdata <= (ctl_read && ctl_address == 3'd1 && status_bit) ? 32'd1 : 32'd0;
    end

    // Readback sink: always ready, or ready on alternate cycles
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rb_alt ? ~m_ready : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s got=%h required=none", name, got);
    endtask

    // Monitor: pop and compare on every output event
    logic [48:0] mon_e;
    logic        prev_stall = 1'b0;
    logic [31:0] hold_data  = '0;
    always @(negedge clk) begin
        if (vc_write) begin
            if (exp_vc.size() == 0) unexpected("vc_write", 64'({vc_address, vc_wdata}));
            else begin
                mon_e = exp_vc.pop_front();
                check("vc_write", 64'({vc_address, vc_wdata}), 64'(mon_e));
            end
        end
        if (ctl_write) begin
            if (exp_ctl.size() == 0) unexpected("ctl_write", 64'({ctl_address, ctl_wdata}));
            else begin
                mon_e = exp_ctl.pop_front();
                check("ctl_write", 64'({14'd0, ctl_address, ctl_wdata}), 64'(mon_e));
            end
        end
        if (to_ctl_write) begin
            if (exp_ctl_to.size() == 0) unexpected("to_ctl_write", 64'({to_ctl_address, to_ctl_wdata}));
            else begin
                mon_e = exp_ctl_to.pop_front();
                check("to_ctl_write", 64'({14'd0, to_ctl_address, to_ctl_wdata}), 64'(mon_e));
            end
        end
        if (to_vc_write || to_vc_read || to_m_valid)
            unexpected("to_vc_activity", 64'({to_vc_write, to_vc_read, to_m_valid}));
        if (prev_stall) check("m_hold", 64'({m_valid, m_data}), 64'({1'b1, hold_data}));
        if (m_valid && m_ready) begin
            if (exp_m.size() == 0) unexpected("m_data", 64'(m_data));
            else check("m_data", 64'(m_data), 64'(exp_m.pop_front()));
        end
        prev_stall = m_valid && !m_ready;
        hold_data  = m_data;
    end

    task automatic drive_word(input logic [32:0] v);
        s_valid = v[32];
        s_data  = v[31:0];
        @(negedge clk);
        check("s_ready_load", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check("done_set", 64'(done), 64'd1);
        check("err_clear", 64'(err), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    logic [32:0] run1 [7] = '{{1'b1, 32'd1}, {1'b1, 32'd12}, {1'b1, 32'd7},
                              {1'b1, 32'hA5A5_0000}, {1'b0, 32'hDEAD_0000},
                              {1'b0, 32'hDEAD_0001}, {1'b1, 32'hA5A5_0001}};
    logic [32:0] run2 [4] = '{{1'b1, 32'hC0DE_0000}, {1'b1, 32'hC0DE_0001},
                              {1'b1, 32'hC0DE_0002}, {1'b1, 32'hBEEF_0000}};
    int poll_n;

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_start_to = 1'b0;
        data_base = '0; data_count = '0; prog_count = '0; rb_base = '0; rb_count = '0;
        core_mask = '0; s_data = '0; s_valid = 1'b0; status_bit = 1'b0; rb_alt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'({s_ready, m_valid, busy, done, err, vc_write, vc_read, ctl_write, ctl_read}), 64'd0);
        check("rst_addr", 64'({vc_address, ctl_address, m_data}), 64'd0);
        check("rst_byteenable", 64'(vc_byteenable), 64'hF);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Run 1: data+prog load with stream gaps, core enables, late status, stalled readback
        data_base = 17'd0; data_count = 17'd3; prog_count = 17'd2;
        core_mask = 4'b1010; rb_base = 17'd7; rb_count = 17'd3;
        exp_vc.push_back({17'h00000, 32'd1});
        exp_vc.push_back({17'h00001, 32'd12});
        exp_vc.push_back({17'h00002, 32'd7});
        exp_vc.push_back({17'h10000, 32'hA5A5_0000});
        exp_vc.push_back({17'h10001, 32'hA5A5_0001});
        exp_ctl.push_back({17'd2, 32'd0});
        exp_ctl.push_back({17'd3, 32'd1});
        exp_ctl.push_back({17'd4, 32'd0});
        exp_ctl.push_back({17'd5, 32'd1});
        exp_ctl.push_back({17'd0, 32'd1});
        exp_m.push_back(32'd1); exp_m.push_back(32'd2); exp_m.push_back(32'd3);
        pulse_start();
        check("busy_load", 64'(busy), 64'd1);
        for (int i = 0; i < 7; i++) drive_word(run1[i]);
        s_valid = 1'b0;
        @(negedge clk);
        check("s_ready_after_load", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        repeat (20) @(posedge clk);
        #1;
        // A start request while polling must be ignored
        data_count = 17'd9;
        pulse_start();
        check("poll_ignores_start", 64'({busy, ctl_read, s_ready}), 64'b110);
        repeat (480) @(posedge clk);
        #1;
        rb_alt = 1'b1;
        status_bit = 1'b1;
        wait_done(200);
        check("m_valid_idle", 64'(m_valid), 64'd0);
        check("queues_run1", 64'({exp_vc.size(), exp_ctl.size(), exp_m.size()}), 64'd0);
        rb_alt = 1'b0;
        status_bit = 1'b0;

        // Timeout instance: all counts zero, status never set
        data_count = '0; prog_count = '0; rb_count = '0; core_mask = 4'b0011;
        exp_ctl_to.push_back({17'd2, 32'd1});
        exp_ctl_to.push_back({17'd3, 32'd1});
        exp_ctl_to.push_back({17'd4, 32'd0});
        exp_ctl_to.push_back({17'd5, 32'd0});
        exp_ctl_to.push_back({17'd0, 32'd1});
        cmd_start_to = 1'b1;
        @(posedge clk);
        #1;
        cmd_start_to = 1'b0;
        check("to_busy_running", 64'(to_busy), 64'd1);
        poll_n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (to_ctl_read) poll_n++;
            if (to_err) break;
        end
        check("to_err_set", 64'(to_err), 64'd1);
        check("to_poll_cycles", 64'(poll_n), 64'd100);
        check("to_flags", 64'({to_busy, to_done, to_m_valid}), 64'd0);
        check("to_queue", 64'(exp_ctl_to.size()), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a program load
        data_base = 17'h00040; data_count = 17'd1; prog_count = 17'd3;
        core_mask = 4'b0000; rb_count = 17'd0;
        exp_vc.push_back({17'h00040, 32'h0000_0011});
        exp_vc.push_back({17'h10000, 32'h0000_0022});
        pulse_start();
        drive_word({1'b1, 32'h0000_0011});
        drive_word({1'b1, 32'h0000_0022});
        s_data = 32'h0000_0033;
        rst = 1'b1;
        #1;
        check("midrst_outputs", 64'({s_ready, busy, done, err, vc_write, vc_read, ctl_write, ctl_read}), 64'd0);
        check("midrst_addr", 64'({vc_address, vc_wdata}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst = 1'b0;
        check("queue_midrst", 64'(exp_vc.size()), 64'd0);
        @(posedge clk);
        #1;

        // Run 2: wrapping data addresses, readback across the wrap
        data_base = 17'h1FFFE; data_count = 17'd3; prog_count = 17'd1;
        core_mask = 4'b0101; rb_base = 17'h1FFFF; rb_count = 17'd2;
        exp_vc.push_back({17'h1FFFE, 32'hC0DE_0000});
        exp_vc.push_back({17'h1FFFF, 32'hC0DE_0001});
        exp_vc.push_back({17'h00000, 32'hC0DE_0002});
        exp_vc.push_back({17'h10000, 32'hBEEF_0000});
        exp_ctl.push_back({17'd2, 32'd1});
        exp_ctl.push_back({17'd3, 32'd0});
        exp_ctl.push_back({17'd4, 32'd1});
        exp_ctl.push_back({17'd5, 32'd0});
        exp_ctl.push_back({17'd0, 32'd1});
        exp_m.push_back(32'hC0DE_0001);
        exp_m.push_back(32'hC0DE_0002);
        pulse_start();
        check("restart_clears_flags", 64'({busy, done, err}), 64'b100);
        for (int i = 0; i < 4; i++) drive_word(run2[i]);
        s_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        status_bit = 1'b1;
        wait_done(100);
        check("queues_run2", 64'({exp_vc.size(), exp_ctl.size(), exp_m.size()}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

endmodule
